// File: rtl/axis_input_sched.sv
// axis_input_sched: per-iteration packet gating of the w/px1/px2 streams feeding a pipe; cfg-to-first-valid latency is 1 cycle.
// Valid and ready are gated combinationally, so backpressure passes straight through; INPUT_SCHED_TIMEOUT_EN adds a DRAIN watchdog.
module axis_input_sched #(
   parameter int ITR_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [ITR_WIDTH-1:0] cfg_iterations,
   input  logic                 cfg_is_max,
   input  logic                 s_w_tvalid_in,
   input  logic                 s_w_tlast_in,
   input  logic                 s_w_tready_in,
   output logic                 s_w_tvalid_out,
   output logic                 s_w_tready_out,
   input  logic                 s_px1_tvalid_in,
   input  logic                 s_px1_tlast_in,
   input  logic                 s_px1_tready_in,
   output logic                 s_px1_tvalid_out,
   output logic                 s_px1_tready_out,
   input  logic                 s_px2_tvalid_in,
   input  logic                 s_px2_tlast_in,
   input  logic                 s_px2_tready_in,
   output logic                 s_px2_tvalid_out,
   output logic                 s_px2_tready_out,
   input  logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   input  logic                 m_axis_tlast,
   output logic                 busy,
   output logic                 done,
   output logic [ITR_WIDTH-1:0] itr_count,
   output logic                 timeout_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]           state_q, state_d;
   logic [ITR_WIDTH-1:0] n_q, n_d;
   logic [ITR_WIDTH-1:0] itr_count_q, itr_count_d;
   logic [ITR_WIDTH-1:0] itr_inc;
   logic                 is_max_q, is_max_d;
   logic                 en_w_q, en_w_d;
   logic                 en_px1_q, en_px1_d;
   logic                 en_px2_q, en_px2_d;
   logic                 pipe_last_q, pipe_last_d;
   logic                 w_last_hs, px1_last_hs, px2_last_hs;
   logic                 m_hs, m_last_hs;

`ifdef INPUT_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_err_q, timeout_err_d;
   assign timeout_err = timeout_err_q;
`else
   logic timeout_cfg_unused;
   assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
   assign timeout_err        = 1'b0;
`endif

   assign s_w_tvalid_out   = s_w_tvalid_in   & en_w_q;
   assign s_w_tready_out   = s_w_tready_in   & en_w_q;
   assign s_px1_tvalid_out = s_px1_tvalid_in & en_px1_q;
   assign s_px1_tready_out = s_px1_tready_in & en_px1_q;
   assign s_px2_tvalid_out = s_px2_tvalid_in & en_px2_q;
   assign s_px2_tready_out = s_px2_tready_in & en_px2_q;

   assign w_last_hs   = s_w_tvalid_in   & s_w_tready_in   & s_w_tlast_in   & en_w_q;
   assign px1_last_hs = s_px1_tvalid_in & s_px1_tready_in & s_px1_tlast_in & en_px1_q;
   assign px2_last_hs = s_px2_tvalid_in & s_px2_tready_in & s_px2_tlast_in & en_px2_q;
   assign m_hs        = m_axis_tvalid & m_axis_tready;
   assign m_last_hs   = m_hs & m_axis_tlast;
   assign itr_inc     = itr_count_q + ITR_WIDTH'(1);

   assign busy      = (state_q != S_IDLE);
   assign cfg_ready = ~busy;
   assign done      = (state_q == S_DONE);
   assign itr_count = itr_count_q;

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      itr_count_d = itr_count_q;
      is_max_d    = is_max_q;
      en_w_d      = en_w_q;
      en_px1_d    = en_px1_q;
      en_px2_d    = en_px2_q;
      pipe_last_d = pipe_last_q;
`ifdef INPUT_SCHED_TIMEOUT_EN
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               n_d         = (cfg_iterations == '0) ? ITR_WIDTH'(1) : cfg_iterations;
               is_max_d    = cfg_is_max;
               itr_count_d = '0;
               pipe_last_d = 1'b0;
               en_w_d      = 1'b1;
               en_px1_d    = 1'b1;
               en_px2_d    = cfg_is_max;
               state_d     = S_LOAD;
`ifdef INPUT_SCHED_TIMEOUT_EN
               timeout_err_d = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (w_last_hs)   en_w_d   = 1'b0;
            if (px1_last_hs) en_px1_d = 1'b0;
            if (px2_last_hs) en_px2_d = 1'b0;
            // A pipe tlast seen early still counts once we reach DRAIN.
            if (m_last_hs)   pipe_last_d = 1'b1;
            if (!en_w_d && !en_px1_d && !en_px2_d) begin
               state_d = S_DRAIN;
`ifdef INPUT_SCHED_TIMEOUT_EN
               wd_cnt_d = '0;
`endif
            end
         end
         S_DRAIN: begin
            if (pipe_last_q || m_last_hs) begin
               pipe_last_d = 1'b0;
               state_d     = S_NEXT;
            end
`ifdef INPUT_SCHED_TIMEOUT_EN
            else if (m_hs) begin
               wd_cnt_d = '0;
            end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               wd_cnt_d      = '0;
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
`endif
         end
         S_NEXT: begin
            itr_count_d = itr_inc;
            if (itr_inc == n_q) begin
               state_d = S_DONE;
            end else begin
               en_w_d   = 1'b1;
               en_px1_d = 1'b1;
               en_px2_d = is_max_q;
               state_d  = S_LOAD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         itr_count_q <= '0;
         is_max_q    <= 1'b0;
         en_w_q      <= 1'b0;
         en_px1_q    <= 1'b0;
         en_px2_q    <= 1'b0;
         pipe_last_q <= 1'b0;
`ifdef INPUT_SCHED_TIMEOUT_EN
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         itr_count_q <= itr_count_d;
         is_max_q    <= is_max_d;
         en_w_q      <= en_w_d;
         en_px1_q    <= en_px1_d;
         en_px2_q    <= en_px2_d;
         pipe_last_q <= pipe_last_d;
`ifdef INPUT_SCHED_TIMEOUT_EN
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_axis_input_sched.sv
// Bench for axis_input_sched: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_axis_input_sched;

   localparam int TMO = 16;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cfg_valid, cfg_ready, cfg_is_max;
   logic [15:0] cfg_iterations;
   logic        s_w_tvalid_in, s_w_tlast_in, s_w_tready_in, s_w_tvalid_out, s_w_tready_out;
   logic        s_px1_tvalid_in, s_px1_tlast_in, s_px1_tready_in, s_px1_tvalid_out, s_px1_tready_out;
   logic        s_px2_tvalid_in, s_px2_tlast_in, s_px2_tready_in, s_px2_tvalid_out, s_px2_tready_out;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic        busy, done, timeout_err;
   logic [15:0] itr_count;

   int n_cmp  = 0;
   int n_fail = 0;

   axis_input_sched #(.ITR_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
      .aclk(aclk), .areset(areset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_iterations(cfg_iterations), .cfg_is_max(cfg_is_max),
      .s_w_tvalid_in(s_w_tvalid_in), .s_w_tlast_in(s_w_tlast_in), .s_w_tready_in(s_w_tready_in),
      .s_w_tvalid_out(s_w_tvalid_out), .s_w_tready_out(s_w_tready_out),
      .s_px1_tvalid_in(s_px1_tvalid_in), .s_px1_tlast_in(s_px1_tlast_in), .s_px1_tready_in(s_px1_tready_in),
      .s_px1_tvalid_out(s_px1_tvalid_out), .s_px1_tready_out(s_px1_tready_out),
      .s_px2_tvalid_in(s_px2_tvalid_in), .s_px2_tlast_in(s_px2_tlast_in), .s_px2_tready_in(s_px2_tready_in),
      .s_px2_tvalid_out(s_px2_tvalid_out), .s_px2_tready_out(s_px2_tready_out),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done(done), .itr_count(itr_count), .timeout_err(timeout_err)
   );

   always #5 aclk = ~aclk;

   // Behavioural model: phase of the current job, set of streams still owing a packet.
   localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_NEXT = 3, P_DONE = 4;
   int       m_ph = P_IDLE;
   bit [2:0] m_pend = 3'b000;
   int       m_itr = 0, m_n = 1, m_wd = 0;
   bit       m_ismax = 1'b0, m_latched = 1'b0, m_terr = 1'b0, m_ok = 1'b0;

   always @(negedge aclk) begin
      bit [2:0] tv, tr, tl, hs, en;
      bit [9:0] exp_v, act_v;
      bit       mlast, many;
      tv = {s_px2_tvalid_in, s_px1_tvalid_in, s_w_tvalid_in};
      tr = {s_px2_tready_in, s_px1_tready_in, s_w_tready_in};
      tl = {s_px2_tlast_in,  s_px1_tlast_in,  s_w_tlast_in};
      many  = m_axis_tvalid & m_axis_tready;
      mlast = many & m_axis_tlast;
      if (m_ok) begin
         en    = (m_ph == P_LOAD) ? m_pend : 3'b000;
         exp_v = {m_ph != P_IDLE, m_ph == P_IDLE, m_ph == P_DONE, m_terr, tv & en, tr & en};
         act_v = {busy, cfg_ready, done, timeout_err,
                  s_px2_tvalid_out, s_px1_tvalid_out, s_w_tvalid_out,
                  s_px2_tready_out, s_px1_tready_out, s_w_tready_out};
         n_cmp++;
         if (act_v !== exp_v || itr_count !== 16'(m_itr)) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got flags=%b itr=%0d, expected flags=%b itr=%0d",
                     $time, act_v, itr_count, exp_v, m_itr);
         end
      end
      if (areset) begin
         m_ph = P_IDLE; m_pend = 3'b000; m_itr = 0; m_terr = 1'b0;
         m_latched = 1'b0; m_wd = 0; m_ok = 1'b1;
      end else if (m_ok) begin
         case (m_ph)
            P_IDLE: if (cfg_valid) begin
               m_n = (cfg_iterations == 16'd0) ? 1 : int'(cfg_iterations);
               m_ismax = cfg_is_max; m_itr = 0; m_terr = 1'b0; m_latched = 1'b0;
               m_pend = {cfg_is_max, 2'b11}; m_ph = P_LOAD;
            end
            P_LOAD: begin
               hs = tv & tr & tl & m_pend;
               m_pend = m_pend & ~hs;
               if (mlast) m_latched = 1'b1;
               if (m_pend == 3'b000) begin m_ph = P_DRAIN; m_wd = 0; end
            end
            P_DRAIN: begin
               if (m_latched || mlast) begin
                  m_ph = P_NEXT; m_latched = 1'b0;
               end
`ifdef INPUT_SCHED_TIMEOUT_EN
               else if (many) m_wd = 0;
               else begin
                  m_wd++;
                  if (m_wd == TMO) begin m_ph = P_IDLE; m_terr = 1'b1; m_wd = 0; end
               end
`endif
            end
            P_NEXT: begin
               m_itr++;
               if (m_itr == m_n) m_ph = P_DONE;
               else begin m_ph = P_LOAD; m_pend = {m_ismax, 2'b11}; end
            end
            default: m_ph = P_IDLE;
         endcase
      end
   end

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp_val);
      n_cmp++;
      if (act !== exp_val) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_val);
      end
   endtask

   task automatic idle_inputs();
      cfg_valid = 1'b0; cfg_iterations = 16'd1; cfg_is_max = 1'b0;
      s_w_tvalid_in = 1'b0;   s_w_tlast_in = 1'b0;   s_w_tready_in = 1'b1;
      s_px1_tvalid_in = 1'b0; s_px1_tlast_in = 1'b0; s_px1_tready_in = 1'b1;
      s_px2_tvalid_in = 1'b0; s_px2_tlast_in = 1'b0; s_px2_tready_in = 1'b1;
      m_axis_tvalid = 1'b0;   m_axis_tready = 1'b0;  m_axis_tlast = 1'b0;
   endtask

   task automatic reset_pulse();
      areset = 1'b1;
      cyc();
      areset = 1'b0;
   endtask

   initial begin
      int bw, bp, wbeats, pbeats, dones, last_itr;
      bit px2_seen, fin;
      int seq[$];

      idle_inputs();
      areset = 1'b1;
      cyc(); cyc();
      areset = 1'b0;
      @(negedge aclk);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_itr", itr_count, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout_err", timeout_err, 0);

      // N=2, w 10 beats, px1 33 beats, px2 disabled
      cyc();
      s_w_tvalid_in = 1; s_px1_tvalid_in = 1; s_px2_tvalid_in = 1;
      m_axis_tvalid = 1; m_axis_tready = 1; m_axis_tlast = 1;
      cfg_valid = 1; cfg_iterations = 16'd2; cfg_is_max = 0;
      bw = 0; bp = 0; wbeats = 0; pbeats = 0; dones = 0; last_itr = 0; px2_seen = 0; fin = 0;
      cyc();
      cfg_valid = 0;
      @(negedge aclk);
      chk("a_latency_w_valid", s_w_tvalid_out, 1);
      chk("a_latency_px1_valid", s_px1_tvalid_out, 1);
      for (int k = 0; k < 600 && !fin; k++) begin
         if (s_w_tvalid_in && s_w_tready_out) begin wbeats++; bw = s_w_tlast_in ? 0 : bw + 1; end
         if (s_px1_tvalid_in && s_px1_tready_out) begin pbeats++; bp = s_px1_tlast_in ? 0 : bp + 1; end
         if (s_px2_tvalid_out) px2_seen = 1;
         if (done) dones++;
         if (int'(itr_count) != last_itr) begin last_itr = int'(itr_count); seq.push_back(last_itr); end
         if (dones > 0 && !busy) fin = 1;
         else begin
            cyc();
            s_w_tlast_in = (bw == 9);
            s_px1_tlast_in = (bp == 32);
            @(negedge aclk);
         end
      end
      chk("a_finished", fin, 1);
      chk("a_px2_never_valid", px2_seen, 0);
      chk("a_done_pulses", dones, 1);
      chk("a_w_beats", wbeats, 20);
      chk("a_px1_beats", pbeats, 66);
      chk("a_itr_seq_len", seq.size(), 2);
      if (seq.size() == 2) begin
         chk("a_itr_seq0", seq[0], 1);
         chk("a_itr_seq1", seq[1], 2);
      end
      chk("a_itr_final", itr_count, 2);
      chk("a_model_itr", m_itr, 2);
      cyc();
      idle_inputs();

      // is_max=1, w tlast 3 cycles before simultaneous px1/px2 tlast
      cfg_valid = 1; cfg_iterations = 16'd1; cfg_is_max = 1;
      cyc();
      cfg_valid = 0; s_w_tvalid_in = 1; s_w_tlast_in = 1;
      @(negedge aclk);
      chk("b_w_valid", s_w_tvalid_out, 1);
      chk("b_px2_ready_enabled", s_px2_tready_out, 1);
      cyc();
      s_w_tvalid_in = 0; s_w_tlast_in = 0;
      @(negedge aclk);
      chk("b_w_ready_cleared", s_w_tready_out, 0);
      chk("b_px1_ready_held", s_px1_tready_out, 1);
      cyc(); cyc();
      s_px1_tvalid_in = 1; s_px1_tlast_in = 1; s_px2_tvalid_in = 1; s_px2_tlast_in = 1;
      @(negedge aclk);
      chk("b_px_valids", {s_px2_tvalid_out, s_px1_tvalid_out}, 3);
      cyc();
      s_px1_tvalid_in = 0; s_px1_tlast_in = 0; s_px2_tvalid_in = 0; s_px2_tlast_in = 0;
      m_axis_tvalid = 1; m_axis_tready = 1; m_axis_tlast = 1;
      @(negedge aclk);
      chk("b_drain_readies_off", {s_px2_tready_out, s_px1_tready_out, s_w_tready_out}, 0);
      chk("b_drain_busy", busy, 1);
      cyc();
      m_axis_tvalid = 0; m_axis_tready = 0; m_axis_tlast = 0;
      @(negedge aclk);
      chk("b_next_done", done, 0);
      cyc();
      @(negedge aclk);
      chk("b_done_pulse", done, 1);
      chk("b_done_itr", itr_count, 1);
      cyc();
      @(negedge aclk);
      chk("b_idle_after_done", {busy, done}, 0);

      // pipe tlast during LOAD satisfies DRAIN on entry
      cyc();
      cfg_valid = 1; cfg_iterations = 16'd1; cfg_is_max = 0;
      cyc();
      cfg_valid = 0; s_w_tvalid_in = 1; s_w_tlast_in = 1;
      m_axis_tvalid = 1; m_axis_tready = 1; m_axis_tlast = 1;
      @(negedge aclk);
      chk("c_px1_pending", s_px1_tready_out, 1);
      cyc();
      s_w_tvalid_in = 0; s_w_tlast_in = 0;
      m_axis_tvalid = 0; m_axis_tready = 0; m_axis_tlast = 0;
      s_px1_tvalid_in = 1; s_px1_tlast_in = 1;
      @(negedge aclk);
      chk("c_px1_valid", s_px1_tvalid_out, 1);
      cyc();
      s_px1_tvalid_in = 0; s_px1_tlast_in = 0;
      @(negedge aclk);
      chk("c_drain_busy", busy, 1);
      cyc();
      @(negedge aclk);
      chk("c_next_no_done", done, 0);
      cyc();
      @(negedge aclk);
      chk("c_done_pulse", done, 1);
      chk("c_itr", itr_count, 1);

      // reset mid-LOAD
      cyc();
      cfg_valid = 1; cfg_iterations = 16'd3; cfg_is_max = 1;
      s_w_tvalid_in = 1; s_px1_tvalid_in = 1; s_px2_tvalid_in = 1;
      cyc();
      cfg_valid = 0;
      @(negedge aclk);
      chk("d_px2_valid_in_load", s_px2_tvalid_out, 1);
      cyc();
      areset = 1;
      cyc();
      areset = 0;
      @(negedge aclk);
      chk("d_valids_dropped", {s_px2_tvalid_out, s_px1_tvalid_out, s_w_tvalid_out}, 0);
      chk("d_itr_cleared", itr_count, 0);
      chk("d_cfg_ready", cfg_ready, 1);
      chk("d_not_busy", busy, 0);
      chk("d_model_idle", m_ph, P_IDLE);
      cyc();
      idle_inputs();

      // DRAIN with no pipe activity
      cfg_valid = 1; cfg_iterations = 16'd1; cfg_is_max = 0;
      s_w_tvalid_in = 1; s_w_tlast_in = 1; s_px1_tvalid_in = 1; s_px1_tlast_in = 1;
      cyc();
      cfg_valid = 0;
      cyc();
      s_w_tvalid_in = 0; s_w_tlast_in = 0; s_px1_tvalid_in = 0; s_px1_tlast_in = 0;
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge aclk);
         if (done) dones++;
         cyc();
      end
      @(negedge aclk);
      chk("e_no_done", dones, 0);
`ifdef INPUT_SCHED_TIMEOUT_EN
      chk("e_timeout_err", timeout_err, 1);
      chk("e_back_idle", busy, 0);
      cyc();
      cfg_valid = 1;
      cyc();
      cfg_valid = 0;
      @(negedge aclk);
      chk("e_err_cleared_on_start", timeout_err, 0);
      chk("e_restart_busy", busy, 1);
`else
      chk("e_timeout_err_tied", timeout_err, 0);
      chk("e_still_draining", busy, 1);
`endif
      cyc();
      reset_pulse();
      idle_inputs();

      // cfg_iterations=0 runs exactly one iteration
      cfg_valid = 1; cfg_iterations = 16'd0; cfg_is_max = 0;
      s_w_tvalid_in = 1; s_w_tlast_in = 1; s_px1_tvalid_in = 1; s_px1_tlast_in = 1;
      m_axis_tvalid = 1; m_axis_tready = 1; m_axis_tlast = 1;
      cyc();
      cfg_valid = 0;
      dones = 0; fin = 0;
      for (int k = 0; k < 50 && !fin; k++) begin
         @(negedge aclk);
         if (done) dones++;
         if (!busy) fin = 1;
         else cyc();
      end
      chk("f_finished", fin, 1);
      chk("f_done_once", dones, 1);
      chk("f_itr_one", itr_count, 1);
      cyc();
      idle_inputs();

      // randomized traffic, model-checked every cycle
      for (int k = 0; k < 3000; k++) begin
         cyc();
         areset          = ($urandom_range(0, 199) == 0);
         cfg_valid       = ($urandom_range(0, 3) == 0);
         cfg_iterations  = 16'($urandom_range(0, 3));
         cfg_is_max      = 1'($urandom_range(0, 1));
         s_w_tvalid_in   = ($urandom_range(0, 3) != 0);
         s_w_tready_in   = ($urandom_range(0, 3) != 0);
         s_w_tlast_in    = ($urandom_range(0, 3) == 0);
         s_px1_tvalid_in = ($urandom_range(0, 3) != 0);
         s_px1_tready_in = ($urandom_range(0, 3) != 0);
         s_px1_tlast_in  = ($urandom_range(0, 4) == 0);
         s_px2_tvalid_in = ($urandom_range(0, 3) != 0);
         s_px2_tready_in = ($urandom_range(0, 3) != 0);
         s_px2_tlast_in  = ($urandom_range(0, 4) == 0);
         m_axis_tvalid   = 1'($urandom_range(0, 1));
         m_axis_tready   = ($urandom_range(0, 3) != 0);
         m_axis_tlast    = ($urandom_range(0, 2) == 0);
      end
      cyc();
      areset = 0;
      idle_inputs();
      cyc();
      @(negedge aclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete, expected completion before 1000000");
      $fatal(1);
   end

endmodule

// File: doc/axis_input_sched.md
AXIS_INPUT_SCHED -- requirements
Module: axis_input_sched

Interface
REQ-001 SHALL have parameter ITR_WIDTH, default 16, width of iteration count.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, drain watchdog limit (used only with macro).
REQ-003 SHALL have port aclk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid / cfg_ready  in / out  1  start-command handshake.
REQ-006 SHALL have port cfg_iterations  in  ITR_WIDTH  iteration count N; 0 treated as 1.
REQ-007 SHALL have port cfg_is_max  in  1  enables the pixels_2 stream.
REQ-008 SHALL have ports s_<x>_tvalid_in, s_<x>_tlast_in  in  1 each, upstream valid/last for x in {w, px1, px2}.
REQ-009 SHALL have ports s_<x>_tready_in  in  1 each, pipe-side ready for x in {w, px1, px2}.
REQ-010 SHALL have ports s_<x>_tvalid_out / s_<x>_tready_out  out  1 each, gated valid to pipe / gated ready to upstream.
REQ-011 SHALL have ports m_axis_tvalid, m_axis_tready, m_axis_tlast  in  1 each, monitored pipe output handshake.
REQ-012 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), itr_count  out  ITR_WIDTH, timeout_err  out  1.

Function
REQ-013 SHALL gate stream x as tvalid_out = tvalid_in & en_x and tready_out = tready_in & en_x, combinationally.
REQ-014 SHALL implement states IDLE, LOAD, DRAIN, NEXT, DONE.
REQ-015 IDLE: cfg_ready=1; on cfg_valid, SHALL latch N and is_max, clear itr_count, go to LOAD next cycle.
REQ-016 LOAD: SHALL set en_w=1, en_px1=1, en_px2=is_max; on each handshake with tlast_in on stream x, SHALL clear en_x from the next cycle.
REQ-017 LOAD SHALL go to DRAIN in the cycle after all enabled streams have completed, including completion of several streams in the same cycle.
REQ-018 DRAIN: all en_x=0; on m_axis_tvalid & m_axis_tready & m_axis_tlast, SHALL go to NEXT.
REQ-019 A pipe tlast arriving during LOAD SHALL be latched and SHALL satisfy DRAIN immediately on entry.
REQ-020 NEXT: SHALL increment itr_count; if the new value equals N, go to DONE, else go to LOAD.
REQ-021 DONE: SHALL assert done for exactly one cycle, then return to IDLE; itr_count SHALL hold until the next start.
REQ-022 busy SHALL be 1 in every state except IDLE; cfg_ready SHALL equal ~busy.
REQ-023 Latency from cfg handshake to first gated tvalid_out SHALL be 1 cycle.
REQ-024 The block SHALL count packets only and SHALL NOT alter data or tkeep.

Reset
REQ-025 areset=1 at a clock edge SHALL force IDLE, all en_x=0, busy=0, done=0, itr_count=0, timeout_err=0, latched tlast=0.
REQ-026 Reset mid-packet SHALL drop gating in the next cycle; recovery of the partial upstream packet is the responsibility of the upstream source.

Configuration
REQ-027 With INPUT_SCHED_TIMEOUT_EN defined, a DRAIN watchdog SHALL count cycles without an m_axis handshake; at TIMEOUT_CYCLES it SHALL set sticky timeout_err and go to IDLE without pulsing done.
REQ-028 With INPUT_SCHED_TIMEOUT_EN undefined, the watchdog SHALL NOT be implemented, timeout_err SHALL be tied to 0, and DRAIN SHALL wait indefinitely.
REQ-029 timeout_err SHALL clear only on reset or on the next accepted cfg handshake.

Verification
REQ-030 N=2, is_max=0, w packet 10 beats, px1 packet 33 beats, readies=1 -> px2 never enabled; itr_count sequence 1,2; one done pulse.
REQ-031 is_max=1, px1 tlast and px2 tlast in the same cycle, w tlast 3 cycles earlier -> LOAD to DRAIN exactly 1 cycle after the px tlasts.
REQ-032 Pipe m_axis_tlast handshake during LOAD (before px1 completes) -> DRAIN exits to NEXT on its first cycle.
REQ-033 areset pulsed 1 cycle during LOAD of iteration 1 (N=3) -> next cycle IDLE, all tvalid_out=0, itr_count=0, cfg_ready=1.
REQ-034 With macro, TIMEOUT_CYCLES=16 and m_axis_tvalid held 0 in DRAIN -> timeout_err=1 after 16 cycles, IDLE, no done; without macro -> stays in DRAIN, timeout_err=0.
REQ-035 cfg_iterations=0 -> exactly one iteration runs, done pulses once, itr_count=1.
